// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter slice. It holds the ALU function
// codes, the arbiter FSM states, the condition-code reset values and a small
// helper that masks the overflow flag for logical operations.
package alu_arbiter_pkg;

  // ALU function codes as they arrive on the request ports.
  // SUB computes B-A, which is the operand order of Y86 subq.
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } aluFun_t;

  // Arbiter FSM states. Only one transaction is in flight at a time.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_EXEC = 2'b01,
    ARB_RESP = 2'b10
  } arbState_t;

  // Condition codes after reset: the register reads as "last result was zero".
  localparam logic CC_ZF_RST = 1'b1;
  localparam logic CC_SF_RST = 1'b0;
  localparam logic CC_OF_RST = 1'b0;

  // Overflow only has a meaning for add/sub. For and/xor it is reported as 0.
  function automatic logic ofMask(input aluFun_t fun, input logic of);
    return ((fun == ALU_ADD) || (fun == ALU_SUB)) ? of : 1'b0;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Bundles the request/response handshakes of both requester ports and the
// condition-code outputs of the ALU arbiter.
//   req0_*/req1_*  : request valid/ready, function code, operands
//                    (set_cc exists only on port 0)
//   rsp0_*/rsp1_*  : response valid/ready for each port
//   rsp_data/rsp_of: registered result and overflow, shared by both ports
//   cc_zf/sf/of    : condition-code register
// The master modport is the requester side. The slave modport is the arbiter.
interface alu_arbiter_if #(
  parameter int W = 64
);
  logic         req0_valid;
  logic         req0_ready;
  logic [1:0]   req0_fun;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_set_cc;

  logic         req1_valid;
  logic         req1_ready;
  logic [1:0]   req1_fun;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;

  logic         rsp0_valid;
  logic         rsp0_ready;
  logic         rsp1_valid;
  logic         rsp1_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_of;

  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;

  modport master (
    output req0_valid, req0_fun, req0_a, req0_b, req0_set_cc,
    output req1_valid, req1_fun, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_of,
    input  cc_zf, cc_sf, cc_of
  );

  modport slave (
    input  req0_valid, req0_fun, req0_a, req0_b, req0_set_cc,
    input  req1_valid, req1_fun, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_of,
    output cc_zf, cc_sf, cc_of
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu
// Purely combinational W-bit ALU. This is the single shared ALU.
//   fun_i    : function code (add, B-A, and, xor)
//   a_i, b_i : operands
//   result_o : result, wrapping modulo 2^W
//   of_o     : signed overflow for add/sub, 0 for logical operations
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int W = 64
) (
  input  aluFun_t      fun_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] result_o,
  output logic         of_o
);

  // Overflow detection for signed arithmetic.
  // Add overflows when both operands share a sign and the result does not.
  // B-A overflows when the operand signs differ and the result sign differs
  // from B.
  always_comb begin
    result_o = '0;
    of_o     = 1'b0;
    case (fun_i)
      ALU_ADD: begin
        result_o = a_i + b_i;
        of_o     = (a_i[W-1] == b_i[W-1]) && (result_o[W-1] != a_i[W-1]);
      end
      ALU_SUB: begin
        result_o = b_i - a_i;
        of_o     = (a_i[W-1] != b_i[W-1]) && (result_o[W-1] != b_i[W-1]);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one ALU between the execute stage (port 0) and the address/auxiliary
// path (port 1). Requests are granted round-robin, one transaction is in
// flight at a time, and results come back through a registered response.
// The block also owns the Y86 condition codes, which only port 0 can update.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of alu_arbiter_if (request/response handshakes, CC)
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W = 64
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  arbState_t    state_q, state_d;
  logic         prio_q;
  logic         id_q;
  logic         setCc_q;
  aluFun_t      fun_q;
  logic [W-1:0] a_q, b_q;
  logic [W-1:0] rspData_q;
  logic         rspOf_q;
  logic         ccZf_q, ccSf_q, ccOf_q;

  logic         grant0, grant1, accept;
  logic [W-1:0] aluResult;
  logic         aluOf, ofMasked;

  // Round-robin choice among the valid requests: a lone requester always
  // wins, and on contention the favoured port (prio_q) wins. This depends
  // only on the valids, never on the request payload.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~prio_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid |  prio_q);
  assign accept = (state_q == ARB_IDLE) & (grant0 | grant1);

  alu_arbiter_alu #(.W(W)) u_alu (
    .fun_i    (fun_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (aluResult),
    .of_o     (aluOf)
  );

  assign ofMasked = ofMask(fun_q, aluOf);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs. Readies are offered only in IDLE and
  // only to the round-robin winner. In RESP, only the owning port sees valid.
  always_comb begin
    state_d        = state_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        if (grant0 | grant1) state_d = ARB_EXEC;
      end
      ARB_EXEC: state_d = ARB_RESP;
      ARB_RESP: begin
        bus.rsp0_valid = ~id_q;
        bus.rsp1_valid =  id_q;
        if ((~id_q & bus.rsp0_ready) | (id_q & bus.rsp1_ready)) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Request capture on the IDLE handshake. Port 1 can never ask for a CC
  // update, so its set_cc is forced low. prio moves to the port that was
  // not just served.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      setCc_q <= 1'b0;
      fun_q   <= ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
    end else if (accept) begin
      id_q    <= grant1;
      prio_q  <= grant0;
      setCc_q <= grant0 & bus.req0_set_cc;
      fun_q   <= grant0 ? aluFun_t'(bus.req0_fun) : aluFun_t'(bus.req1_fun);
      a_q     <= grant0 ? bus.req0_a : bus.req1_a;
      b_q     <= grant0 ? bus.req0_b : bus.req1_b;
    end
  end

  // Response register. It is loaded once in EXEC and then held through RESP
  // and beyond, so the result stays stable while the requester stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rspData_q <= '0;
      rspOf_q   <= 1'b0;
    end else if (state_q == ARB_EXEC) begin
      rspData_q <= aluResult;
      rspOf_q   <= ofMasked;
    end
  end

  // Condition-code register. It updates on the same edge as the response
  // register, so new flags appear together with rsp_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ccZf_q <= CC_ZF_RST;
      ccSf_q <= CC_SF_RST;
      ccOf_q <= CC_OF_RST;
    end else if ((state_q == ARB_EXEC) && setCc_q) begin
      ccZf_q <= (aluResult == '0);
      ccSf_q <= aluResult[W-1];
      ccOf_q <= ofMasked;
    end
  end

  assign bus.rsp_data = rspData_q;
  assign bus.rsp_of   = rspOf_q;
  assign bus.cc_zf    = ccZf_q;
  assign bus.cc_sf    = ccSf_q;
  assign bus.cc_of    = ccOf_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 64-bit `ALU` (add / sub / and / xor) between two requesters: port 0 is the execute stage and port 1 is the address/auxiliary computation path. Each port uses a valid/ready request and a valid/ready response. Arbitration is round-robin. The block owns the Y86 condition-code register (ZF, SF, OF), which only port-0 operations may update. One transaction is in flight at a time, and the response is registered.

## Interface
- `W`, default 64: operand/result width. Fixed to the ALU datapath width.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset. Synchronous, active-low.
- `req0_valid`, `req1_valid` in 1: request present on port 0 / 1.
- `req0_ready`, `req1_ready` out 1: request accepted this cycle when both valid and ready are high.
- `req0_fun`, `req1_fun` in 2: ALU function. 00 = A+B, 01 = B−A, 10 = A&B, 11 = A^B.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in W: operands.
- `req0_set_cc` in 1: on completion, update the CC register from this operation.
- `rsp0_valid`, `rsp1_valid` out 1: a result is pending for that port.
- `rsp0_ready`, `rsp1_ready` in 1: the requester accepts the result.
- `rsp_data` out W: registered result, shared by both ports.
- `rsp_of` out 1: registered overflow flag. Valid for fun 00/01; 0 for fun 10/11.
- `cc_zf`, `cc_sf`, `cc_of` out 1: condition-code register.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Ready is asserted to exactly one port, the one chosen by round-robin among the valid requests.
  - If only one port is valid, that port gets ready.
  - If neither is valid, neither ready is asserted.
  - A handshake latches fun, a, b, set_cc (forced to 0 for port 1) and the granted port ID, then moves to EXEC.
- Round-robin:
  - The `prio` bit names the favoured port. Reset value is 0.
  - After each grant, `prio` becomes the other port.
  - If both ports are valid, `prio` wins.
- EXEC:
  - The latched operands drive the `ALU`.
  - At the clock edge, ALU out goes to `rsp_data`, and OF (masked to 0 for fun 1x) goes to `rsp_of`.
  - If latched set_cc = 1, the CC register updates on the same edge: ZF = (result == 0), SF = result[W−1], OF = masked OF.
  - The FSM then moves to RESP.
- RESP:
  - `rsp<id>_valid` = 1. The other port's rsp_valid = 0.
  - Both req readies are low.
  - `rsp_data` and `rsp_of` hold steady until the handshake.
  - On `rsp<id>_ready` the FSM moves to IDLE. New requests are accepted from the next cycle on.
- Arithmetic: results wrap modulo 2^W. Sub is B−A, in Y86 `subq` operand order.
- Port 1 never changes CC. A `req1_set_cc` input does not exist.

## Timing
- Reset (`rst_n` low at an edge):
  - State → IDLE, `prio` → 0.
  - All readies and rsp_valids → 0.
  - `rsp_data` → 0, `rsp_of` → 0.
  - CC → ZF = 1, SF = 0, OF = 0.
- Reset mid-transaction (EXEC or RESP): the transaction is dropped and no response is issued.
- Latency: handshake at edge N, result registered at edge N+1, rsp_valid high in the cycle after N+1.
- Throughput: at best one operation every 3 cycles (rsp_ready held high).
- CC visibility: a CC update is visible on `cc_*` in the same cycle that rsp_valid rises.
- Readies are combinational from state, `prio` and req valids. They must not depend on req data.
- Requesters must hold valid and payload stable until the handshake. A requester withdrawing valid before ready is legal and causes no grant.
- A req valid arriving while in RESP is held off until IDLE.

## Structure
- Shared package/header `alu_defs.vh`:
  - ALU function codes `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_XOR`.
  - FSM state encodings `ARB_IDLE`, `ARB_EXEC`, `ARB_RESP`.
  - CC reset values.
- Exactly one sub-module: the existing `ALU`, instantiated once. No other ALU copies.
- The CC register is a separate `always` block inside this module. It is not its own sub-module.

## Test plan
- Reset then single add:
  - Stimulus: port 0 add, a = 5, b = 7, set_cc = 1.
  - Expected: rsp0_valid 2 cycles after the handshake; rsp_data = 12, rsp_of = 0; CC = Z0 S0 O0.
- Sub with overflow:
  - Stimulus: port 0 sub, a = 1, b = 0x8000_0000_0000_0000, set_cc = 1.
  - Expected: rsp_data = 0x7FFF_FFFF_FFFF_FFFF; rsp_of = 1; CC = Z0 S0 O1.
- Port 1 does not touch CC:
  - Stimulus: port 1 xor, a = b = 0xDEAD.
  - Expected: rsp1_valid, rsp_data = 0, rsp_of = 0; CC unchanged from the prior value.
- Simultaneous requests:
  - Stimulus: both ports valid continuously from reset.
  - Expected: grants alternate 0,1,0,1. Each port sees its own correct results. No rsp_valid ever appears on the wrong port.
- Response backpressure:
  - Stimulus: hold rsp0_ready = 0 for 5 cycles.
  - Expected: rsp_data stable; req readies stay 0; a pending port-1 request is granted the cycle after the rsp0 handshake.
- Reset in EXEC:
  - Stimulus: assert `rst_n` = 0 one cycle after a port-0 grant.
  - Expected: no rsp0_valid appears. CC = Z1 S0 O0. The next grant goes to port 0.
